rf_wb_arbiter: RTL and testbench

//  Write-back arbiter/scheduler for the 8x32 register file's single write port.

---
 rtl/rf_pkg.sv | 20 ++
 rtl/rf_wb_arbiter_if.sv | 16 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/rf_wb_arbiter.sv | 127 ++++++++++++
 tb/tb_rf_wb_arbiter.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared register-file write-back types and widths
package rf_pkg;

  localparam int RF_DW    = 32;
  localparam int RF_AW    = 3;
  localparam int RF_NREGS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DRAIN = 2'd2
  } wb_state_e;

  // "reg" is a keyword, so the destination index field is wreg
  typedef struct packed {
    logic [RF_AW-1:0] wreg;
    logic [RF_DW-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// rtl/rf_wb_arbiter_if.sv - write-back request bus between requesters and the arbiter
interface rf_wb_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int DW      = 32,
  parameter int AW      = 3
);

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*AW-1:0] req_reg;
  logic [NUM_REQ*DW-1:0] req_data;

  modport master (output req_valid, req_reg, req_data, input req_ready);
  modport slave  (input req_valid, req_reg, req_data, output req_ready);

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first request at or above ptr, else lowest
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic [N-1:0] req_i,
  input  logic [1:0]   ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [1:0]   idx_o,
  output logic         any_o
);

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    // first pass covers [ptr, N-1], second pass wraps to [0, ptr-1]
    for (int i = 0; i < N; i++) begin
      if (!any_o && req_i[i] && (i >= int'(ptr_i))) begin
        gnt_o[i] = 1'b1;
        idx_o    = 2'(i);
        any_o    = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!any_o && req_i[i] && (i < int'(ptr_i))) begin
        gnt_o[i] = 1'b1;
        idx_o    = 2'(i);
        any_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - round-robin write-back arbiter for the register file write port
// Optional RAW scoreboard enabled by RF_WB_SCOREBOARD_EN.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DW      = RF_DW,
  parameter int AW      = RF_AW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hold,
  rf_wb_arbiter_if.slave     req_bus,
  output logic               write_en,
  output logic [AW-1:0]      write_reg,
  output logic [DW-1:0]      write_data,
  output logic [1:0]         grant_id,
  input  logic               rsv_valid,
  input  logic [AW-1:0]      rsv_reg,
  output logic [(1<<AW)-1:0] busy
);

  localparam int NREG = 1 << AW;

  wb_state_e          state_q, state_d;
  logic [1:0]         rr_ptr_q, rr_ptr_d;
  logic               write_en_q;
  logic [AW-1:0]      write_reg_q;
  logic [DW-1:0]      write_data_q;
  logic [1:0]         grant_id_q;

  logic               grant_allow;
  logic [NUM_REQ-1:0] gnt;
  logic [1:0]         gnt_idx;
  logic               gnt_any;
  logic [AW-1:0]      sel_reg;
  logic [DW-1:0]      sel_data;

  // DRAIN covers the cycle after hold drops, so a grant needs hold low for two cycles
  assign grant_allow = !hold && (state_q != DRAIN);

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req_i (req_bus.req_valid & {NUM_REQ{grant_allow}}),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  assign req_bus.req_ready = gnt;

  always_comb begin
    sel_reg  = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_reg  = req_bus.req_reg[i*AW +: AW];
        sel_data = req_bus.req_data[i*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    if (gnt_any) begin
      rr_ptr_d = (gnt_idx == 2'(NUM_REQ - 1)) ? 2'd0 : gnt_idx + 2'd1;
    end
    if (hold) begin
      state_d = DRAIN;
    end else begin
      case (state_q)
        IDLE, WRITE: state_d = gnt_any ? WRITE : IDLE;
        DRAIN:       state_d = IDLE;
        default:     state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= 2'd0;
      write_en_q   <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      grant_id_q   <= 2'd0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      write_en_q <= gnt_any;
      if (gnt_any) begin
        write_reg_q  <= sel_reg;
        write_data_q <= sel_data;
        grant_id_q   <= gnt_idx;
      end
    end
  end

  assign write_en   = write_en_q;
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;
  assign grant_id   = grant_id_q;

`ifdef RF_WB_SCOREBOARD_EN
  logic [NREG-1:0] busy_q, busy_d;

  // clear on commit first so a same-cycle reservation of that register wins
  always_comb begin
    busy_d = busy_q;
    if (write_en_q) busy_d[write_reg_q] = 1'b0;
    if (rsv_valid)  busy_d[rsv_reg]     = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy = busy_q;
`else
  logic unused_rsv;
  assign unused_rsv = ^{rsv_valid, rsv_reg};
  assign busy       = {NREG{1'b0}};
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - randomized self-checking bench for rf_wb_arbiter against a queue-level model
module tb_rf_wb_arbiter;
  import rf_pkg::*;

  localparam int NR = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hold = 1'b0;
  logic       rsv_valid = 1'b0;
  logic [2:0] rsv_reg = 3'd0;
  logic       write_en;
  logic [2:0] write_reg;
  logic [31:0] write_data;
  logic [1:0] grant_id;
  logic [7:0] busy;

  rf_wb_arbiter_if #(.NUM_REQ(NR), .DW(32), .AW(3)) bus ();

  rf_wb_arbiter #(.NUM_REQ(NR), .DW(32), .AW(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hold       (hold),
    .req_bus    (bus),
    .write_en   (write_en),
    .write_reg  (write_reg),
    .write_data (write_data),
    .grant_id   (grant_id),
    .rsv_valid  (rsv_valid),
    .rsv_reg    (rsv_reg),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // requester side: each requester holds one pending write until accepted
  logic        v  [NR];
  logic [2:0]  rg [NR];
  logic [31:0] dt [NR];

  // reference model state
  int      ptr;
  bit      prev_hold;
  bit      exp_we;
  wb_req_t exp_wr;
  int      exp_gid;
  bit [7:0] exp_busy;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < NR; i++) begin
      bus.req_valid[i]           = v[i];
      bus.req_reg[i*3 +: 3]      = rg[i];
      bus.req_data[i*32 +: 32]   = dt[i];
    end
  endtask

  task automatic model_reset();
    ptr       = 0;
    prev_hold = 1'b0;
    exp_we    = 1'b0;
    exp_wr    = '0;
    exp_gid   = 0;
    exp_busy  = '0;
    for (int i = 0; i < NR; i++) v[i] = 1'b0;
    rsv_valid = 1'b0;
  endtask

  // called at a falling edge with inputs chosen; returns at the next falling edge
  task automatic step();
    int w;
    logic [2:0] er;
    apply();
    #1;
    w = -1;
    if (!hold && !prev_hold) begin
      for (int k = 0; k < NR; k++) begin
        if (w < 0 && v[(ptr + k) % NR]) w = (ptr + k) % NR;
      end
    end
    er = (w >= 0) ? 3'(1 << w) : 3'd0;
    chk("req_ready", 32'(bus.req_ready), 32'(er));
    @(posedge clk);
`ifdef RF_WB_SCOREBOARD_EN
    if (exp_we) exp_busy[exp_wr.wreg] = 1'b0;
    if (rsv_valid) exp_busy[rsv_reg] = 1'b1;
`endif
    if (w >= 0) begin
      exp_we      = 1'b1;
      exp_wr.wreg = rg[w];
      exp_wr.data = dt[w];
      exp_gid     = w;
      ptr         = (w + 1) % NR;
      v[w]        = 1'b0;
    end else begin
      exp_we = 1'b0;
    end
    prev_hold = hold;
    @(negedge clk);
    chk("write_en", 32'(write_en), 32'(exp_we));
    chk("write_reg", 32'(write_reg), 32'(exp_wr.wreg));
    chk("write_data", write_data, exp_wr.data);
    chk("grant_id", 32'(grant_id), 32'(exp_gid));
    chk("busy", 32'(busy), 32'(exp_busy));
  endtask

  task automatic set_req(input int i, input logic [2:0] r, input logic [31:0] d);
    v[i]  = 1'b1;
    rg[i] = r;
    dt[i] = d;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NR; i++) begin
      rg[i] = 3'd0;
      dt[i] = 32'd0;
    end
    model_reset();
    apply();
    @(negedge clk);
    @(negedge clk);
    chk("rst_write_en", 32'(write_en), 32'd0);
    chk("rst_write_reg", 32'(write_reg), 32'd0);
    chk("rst_write_data", write_data, 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // single request on requester 0
    set_req(0, 3'd3, 32'hDEADBEEF);
    step();
    chk("single_we", 32'(write_en), 32'd1);
    chk("single_reg", 32'(write_reg), 32'd3);
    chk("single_data", write_data, 32'hDEADBEEF);
    chk("single_gid", 32'(grant_id), 32'd0);
    step();
    chk("single_idle_we", 32'(write_en), 32'd0);

`ifdef RF_WB_SCOREBOARD_EN
    rsv_valid = 1'b1; rsv_reg = 3'd5;
    step();
    chk("sb_rsv5", 32'(busy[5]), 32'd1);
    rsv_valid = 1'b0;
    set_req(0, 3'd5, 32'h0000_0055);
    step();
    step();
    chk("sb_commit5", 32'(busy[5]), 32'd0);
    set_req(0, 3'd5, 32'h0000_0056);
    step();
    rsv_valid = 1'b1; rsv_reg = 3'd5;
    step();
    chk("sb_rsv_wins", 32'(busy[5]), 32'd1);
    rsv_valid = 1'b0;
`else
    rsv_valid = 1'b1; rsv_reg = 3'd2;
    step();
    chk("nosb_busy0", 32'(busy), 32'd0);
    rsv_valid = 1'b0;
    step();
    chk("nosb_busy1", 32'(busy), 32'd0);
`endif

    // reset asserted while a write sits on the port
    hold = 1'b0;
    step();
    set_req(2, 3'd7, 32'hCAFE_0002);
    step();
    chk("pre_rst_we", 32'(write_en), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_we", 32'(write_en), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    model_reset();
    apply();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NR; i++) set_req(i, 3'(i + 1), 32'h1000_0000 + 32'(i));
    step();
    chk("post_rst_first", 32'(grant_id), 32'd0);

    // continuous requests: no bubbles, strict rotation starting at 1
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < NR; j++) begin
        if (!v[j]) set_req(j, 3'($urandom), $urandom);
      end
      step();
      chk("rr_we", 32'(write_en), 32'd1);
      chk("rr_order", 32'(grant_id), 32'((1 + i) % NR));
    end

    // hold with requester 1 pending, pointer at 1
    for (int j = 0; j < NR; j++) v[j] = 1'b0;
    set_req(0, 3'd4, 32'hAAAA_0000);
    set_req(1, 3'd6, 32'hBBBB_1111);
    hold = 1'b1;
    step();
    step();
    chk("hold_we", 32'(write_en), 32'd0);
    hold = 1'b0;
    step();
    chk("drain_we", 32'(write_en), 32'd0);
    step();
    chk("hold_rel_gid", 32'(grant_id), 32'd1);
    chk("hold_rel_data", write_data, 32'hBBBB_1111);

    // randomized traffic
    for (int c = 0; c < 500; c++) begin
      for (int j = 0; j < NR; j++) begin
        if (!v[j] && $urandom_range(0, 99) < 55) set_req(j, 3'($urandom), $urandom);
      end
      if ($urandom_range(0, 99) < 8) hold = ~hold;
      rsv_valid = ($urandom_range(0, 99) < 30);
      rsv_reg   = 3'($urandom);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
